seg7_scan_display: RTL

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It consumes BCD digits from the design's counters, such as the 9-to-0 down-counter value on digit 0, and produces active-low anode and segment drives. It sits directly downstream of the counter stage. It provides per-frame snapshotting, leading-zero blanking, a decimal-point mask and a blink mode for end-of-count indication.

---
 rtl/seg7_scan_display.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_display.sv
// 4-digit common-anode 7-seg scanner: per-frame snapshot, leading-zero blanking, dp mask, blink.
// Latency: outputs registered one clk behind scan state; free-running, no backpressure.
module seg7_scan_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
    input  logic        blink,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_out,
    output logic        frame_tick
);
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]         slot_q, slot_d;
    logic [15:0]        snap_bcd_q, snap_bcd_d;
    logic [3:0]         snap_dp_q, snap_dp_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_out_q, dp_out_d;
    logic               frame_tick_q, frame_tick_d;

    logic               frame_end;
    logic [3:0]         cur_digit;
    logic               lz_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        div_cnt_d     = div_cnt_q;
        slot_d        = slot_q;
        snap_bcd_d    = snap_bcd_q;
        snap_dp_d     = snap_dp_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_end     = (slot_q == 2'd3) && (div_cnt_q == DIV_MAX);

        if (div_cnt_q == DIV_MAX) begin
            div_cnt_d = '0;
            slot_d    = slot_q + 2'd1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        if ((slot_q == 2'd0) && (div_cnt_q == '0)) begin
            snap_bcd_d = bcd;
            snap_dp_d  = dp;
        end

        // Held at zero while disabled so enabling blink always starts visible.
        if (!blink) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        cur_digit = 4'h0;
        lz_blank  = 1'b0;
        case (slot_q)
            2'd0: begin
                cur_digit = snap_bcd_q[3:0];
                lz_blank  = 1'b0;
            end
            2'd1: begin
                cur_digit = snap_bcd_q[7:4];
                lz_blank  = (snap_bcd_q[15:4] == 12'h000);
            end
            2'd2: begin
                cur_digit = snap_bcd_q[11:8];
                lz_blank  = (snap_bcd_q[15:8] == 8'h00);
            end
            default: begin
                cur_digit = snap_bcd_q[15:12];
                lz_blank  = (snap_bcd_q[15:12] == 4'h0);
            end
        endcase

        seg_d    = (blank_lz && lz_blank) ? 7'b1111111 : seg_decode(cur_digit);
        dp_out_d = ~snap_dp_q[slot_q];
        // First cycle of each slot is a dark gap to hide ghosting while segments settle.
        if ((div_cnt_q == '0) || (blink && blink_phase_q)) begin
            an_d = 4'b1111;
        end else begin
            an_d = ~(4'b0001 << slot_q);
        end
        // Look ahead one cycle so the registered pulse lines up with the last frame cycle.
        frame_tick_d = (slot_d == 2'd3) && (div_cnt_d == DIV_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q     <= '0;
            slot_q        <= 2'd0;
            snap_bcd_q    <= 16'h0000;
            snap_dp_q     <= 4'h0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= 4'b1111;
            seg_q         <= 7'b1111111;
            dp_out_q      <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            slot_q        <= slot_d;
            snap_bcd_q    <= snap_bcd_d;
            snap_dp_q     <= snap_dp_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_out_q      <= dp_out_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign frame_tick = frame_tick_q;

endmodule
